// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: drives PISO load/shift, line-mux select and parity.
// Optional parity stage is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_controller #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_odd,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] piso_data,
  output logic                 load,
  output logic                 shift,
  output logic [1:0]           sel,
  output logic                 parity_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] piso_q, piso_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load_q, load_d;
  logic                 shift_q, shift_d;
  logic [1:0]           sel_q, sel_d;
  logic                 baud_end;

  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Next-state, counters and registered-output precomputation
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    piso_d  = piso_q;
    load_d  = 1'b0;
    shift_d = 1'b0;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = S_START;
          load_d  = 1'b1;
          piso_d  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ parity_odd;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = 1'b1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        // bit_cnt is reused to count stop bits
        if (baud_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || baud_end || state_q == S_IDLE) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    case (state_d)
      S_START:  sel_d = SEL_START;
      S_DATA:   sel_d = SEL_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: sel_d = SEL_PARITY;
`endif
      default:  sel_d = SEL_STOP;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      piso_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      sel_q   <= SEL_STOP;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      piso_q  <= piso_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      sel_q   <= sel_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
  assign parity_o = parity_q;
`else
  assign parity_o = 1'b0;
`endif

  assign tx_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign piso_data = piso_q;
  assign load      = load_q;
  assign shift     = shift_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: frame-position model checked every cycle plus literal pins.
module tb_uart_tx_controller;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P  = 1;
  localparam int SB = 1;
`else
  localparam int P  = 0;
  localparam int SB = 2;
`endif
  localparam int L = (1 + DB + P + SB) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          parity_odd = 1'b0;
  logic          tx_ready, busy, done, load, shift, parity_o;
  logic [DB-1:0] piso_data;
  logic [1:0]    sel;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  uart_tx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .parity_odd(parity_odd), .tx_ready(tx_ready), .busy(busy), .done(done),
    .piso_data(piso_data), .load(load), .shift(shift), .sel(sel), .parity_o(parity_o)
  );

  always #5 clk = ~clk;

  // Model: position k within the frame (-1 when idle), plus latched payload
  int            m_k = -1;
  logic          m_done = 1'b0;
  logic [DB-1:0] m_piso = '0;
  logic          m_par = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k = -1; m_done = 1'b0; m_piso = '0; m_par = 1'b0;
    end else if (m_k >= 0) begin
      if (m_k == L - 1) begin m_k = -1; m_done = 1'b1; end
      else begin m_k = m_k + 1; m_done = 1'b0; end
    end else begin
      m_done = 1'b0;
      if (tx_valid) begin
        m_k = 0;
        m_piso = tx_data;
        m_par = (P == 1) ? logic'(($countones(tx_data) + int'(parity_odd)) % 2) : 1'b0;
      end
    end
  end

  function automatic logic [15:0] expect_vec(int k, logic dn, logic [DB-1:0] pd, logic pb);
    logic [1:0] s;
    logic ld, sh, rdy, bsy, d;
    int seg;
    if (k < 0) begin
      s = 2'b11; ld = 0; sh = 0; rdy = 1; bsy = 0; d = dn;
    end else begin
      seg = k / CPB;
      if (seg == 0) s = 2'b00;
      else if (seg <= DB) s = 2'b01;
      else if (P == 1 && seg == DB + 1) s = 2'b10;
      else s = 2'b11;
      ld = (k == 0);
      sh = (k % CPB == 0) && (k >= 2 * CPB) && (k <= (DB + 1) * CPB);
      rdy = 0; bsy = 1; d = 0;
    end
    return {rdy, bsy, d, ld, sh, s, pb, pd};
  endfunction

  always @(negedge clk) begin
    logic [15:0] exp_v, act_v;
    if (started && !rst) begin
      exp_v = expect_vec(m_k, m_done, m_piso, m_par);
      act_v = {tx_ready, busy, done, load, shift, sel, parity_o, piso_data};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle k=%0d {rdy,busy,done,load,shift,sel,par,piso} got %h want %h at %0t",
                 m_k, act_v, exp_v, $time);
      end
    end
  end

  // Frame statistics measured from the load cycle
  int mon_cyc = 0, mon_shifts = 0, mon_n10 = 0;
  int last_len = -1, last_shifts = -1, last_n10 = -1, sel10_total = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (load) begin mon_cyc = 0; mon_shifts = 0; mon_n10 = 0; end
      else mon_cyc++;
      if (shift) mon_shifts++;
      if (sel == 2'b10) begin mon_n10++; sel10_total++; end
      if (done) begin last_len = mon_cyc; last_shifts = mon_shifts; last_n10 = mon_n10; end
    end
  end

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic send(input logic [DB-1:0] d, input logic odd);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; parity_odd = odd;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = DB'($urandom); parity_odd = ~odd;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      seen = done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done timeout got 0 want 1", nm);
    end
  endtask

  task automatic frame(input string nm, input logic [DB-1:0] d, input logic odd, input int par_exp);
    send(d, odd);
    wait_done(nm);
    check({nm, "_len"}, last_len, 44);
    check({nm, "_shifts"}, last_shifts, 8);
    check({nm, "_sel10"}, last_n10, 4 * P);
    check({nm, "_piso"}, int'(piso_data), int'(d));
    check({nm, "_parity"}, int'(parity_o), par_exp);
  endtask

  initial begin
    int dcount;
    // Reset acts before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_sel", int'(sel), 3);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_load", int'(load), 0);
    check("rst_shift", int'(shift), 0);
    check("rst_piso", int'(piso_data), 0);
    check("rst_parity", int'(parity_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1;

    frame("a5_even", 8'hA5, 1'b0, 0);
    check("a5_ready_after", int'(tx_ready), 1);
    frame("00_odd", 8'h00, 1'b1, P);
    frame("07_even", 8'h07, 1'b0, P);
    frame("07_odd", 8'h07, 1'b1, 0);

    // Back-to-back with tx_valid held high; data changes while busy are ignored
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h12; parity_odd = 1'b0;
    @(negedge clk);
    tx_data = 8'h34;
    wait_done("b2b_first");
    check("b2b_first_len", last_len, 44);
    @(negedge clk); #1;
    check("b2b_load_after_done", int'(load), 1);
    check("b2b_piso_second", int'(piso_data), 8'h34);
    tx_valid = 1'b0;
    wait_done("b2b_second");
    check("b2b_second_len", last_len, 44);

    // Reset during the third data bit
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hC3; parity_odd = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 100 && m_k != 13; i++) @(negedge clk);
    check("mid_reach_bit2", m_k, 13);
    #2 rst = 1'b1;
    #1;
    check("mid_sel", int'(sel), 3);
    check("mid_busy", int'(busy), 0);
    check("mid_ready", int'(tx_ready), 1);
    check("mid_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (60) begin
      @(negedge clk); #1;
      if (done) dcount++;
    end
    check("mid_no_done", dcount, 0);
    frame("after_rst_3c", 8'h3C, 1'b1, P);

    check("sel10_total", sel10_total, 7 * 4 * P);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
